vga_frame_decoder: RTL and testbench

Receive-side counterpart to the VGA pattern path. It samples the VGA sync, blank and RGB signals produced by `VGA_controller` (board loopback or bench), recovers per-pixel coordinates, and measures line and frame geometry. It locks onto the 640x480 timing and reports a per-frame colour checksum, so a generated pattern such as colour bars can be checked automatically, with no monitor in the loop.

---
 rtl/vga_decode_pkg.sv | 25 ++
 rtl/vga_edge_detect.sv | 28 ++
 rtl/vga_frame_decoder.sv | 214 +++++++++++++++++++++
 tb/tb_vga_frame_decoder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_decode_pkg.sv
// Shared definitions for the VGA receive-side decoder.
//   dec_state_t  : lock FSM states
//   H/V_ACTIVE_DEF : default visible geometry (640x480)
//   CSUM_W, CNT_W  : checksum and coordinate/counter widths
//   sat_inc()      : counter increment that sticks at all-ones
package vga_decode_pkg;

    typedef enum logic [1:0] {
        S_SEARCH  = 2'd0,
        S_MEASURE = 2'd1,
        S_LOCKED  = 2'd2
    } dec_state_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int CSUM_W       = 16;
    localparam int CNT_W        = 10;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_edge_detect.sv
// Falling-edge detector for one sync line, qualified by the pixel strobe.
//   clock, resetn : clock and asynchronous active-low reset
//   enable        : pixel strobe; history only advances on strobe cycles
//   sig           : sync input (idle high)
//   fall          : high during a strobe cycle whose sample is 0 after a 1
module vga_edge_detect (
    input  logic clock,
    input  logic resetn,
    input  logic enable,
    input  logic sig,
    output logic fall
);

    logic prev_reg;

    // Idle-high history so a sync that is already low out of reset does
    // register as an edge on its first sample.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            prev_reg <= 1'b1;
        end else if (enable) begin
            prev_reg <= sig;
        end
    end

    assign fall = enable & prev_reg & ~sig;

endmodule

// File: rtl/vga_frame_decoder.sv
// Samples VGA sync/blank/RGB, recovers pixel coordinates, measures line and
// frame geometry, locks onto the expected timing and reports a per-frame
// 16-bit colour checksum.
//   clock, resetn         : clock, asynchronous active-low reset
//   enable                : pixel strobe qualifying every sample
//   iVGA_H_SYNC/V_SYNC    : active-low syncs; iVGA_BLANK high = visible
//   iVGA_R/G/B            : pixel colour
//   oCoord_X/Y, oR/G/B    : registered pixel, qualified by oPixel_valid
//   oFrame_done           : pulse at each complete frame end
//   oLocked, oError       : lock status, sticky geometry error
//   oLine_pixels          : pixel count of the last line that had pixels
//   oFrame_lines, oChecksum : results of the last complete frame
module vga_frame_decoder import vga_decode_pkg::*; #(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int LOCK_FRAMES = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              enable,
    input  logic              iVGA_H_SYNC,
    input  logic              iVGA_V_SYNC,
    input  logic              iVGA_BLANK,
    input  logic [7:0]        iVGA_R,
    input  logic [7:0]        iVGA_G,
    input  logic [7:0]        iVGA_B,
    output logic [CNT_W-1:0]  oCoord_X,
    output logic [CNT_W-1:0]  oCoord_Y,
    output logic              oPixel_valid,
    output logic [7:0]        oR,
    output logic [7:0]        oG,
    output logic [7:0]        oB,
    output logic              oFrame_done,
    output logic              oLocked,
    output logic [CNT_W-1:0]  oLine_pixels,
    output logic [CNT_W-1:0]  oFrame_lines,
    output logic [CSUM_W-1:0] oChecksum,
    output logic              oError
);

    localparam int GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

    // ---------------- sync edge detection (bit 0 = hsync, bit 1 = vsync)
    logic [1:0] sync_in;
    logic [1:0] sync_fall;
    logic       hfall;
    logic       vfall;

    assign sync_in = {iVGA_V_SYNC, iVGA_H_SYNC};

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync_edge
        vga_edge_detect u_edge (
            .clock  (clock),
            .resetn (resetn),
            .enable (enable),
            .sig    (sync_in[gi]),
            .fall   (sync_fall[gi])
        );
    end

    assign hfall = sync_fall[0];
    assign vfall = sync_fall[1];

    // ---------------- datapath state
    logic [CNT_W-1:0]  pix_cnt_reg, y_reg;
    logic [CSUM_W-1:0] sum_reg;
    logic              bad_line_reg;
    logic              seen_vs_reg;   // a vsync fall has opened a frame
    logic [CNT_W-1:0]  coord_x_reg, coord_y_reg, line_pixels_reg, frame_lines_reg;
    logic [7:0]        r_reg, g_reg, b_reg;
    logic              pixel_valid_reg, frame_done_reg;
    logic [CSUM_W-1:0] checksum_reg;

    // ---------------- line/frame bookkeeping for the current sample.
    // Blank lines (vertical blanking) have no pixels and are neither counted
    // nor checked. A line ending in the same sample as vsync falls is folded
    // into the frame before it is evaluated.
    logic              line_has;
    logic              line_bad;
    logic [CNT_W-1:0]  y_after_line;
    logic              frame_good;
    logic [CNT_W-1:0]  pix_base, y_base;
    logic [CSUM_W-1:0] sum_base, sum_term;

    always_comb begin
        line_has     = hfall && (pix_cnt_reg != '0);
        line_bad     = line_has && (pix_cnt_reg != CNT_W'(H_ACTIVE));
        y_after_line = line_has ? sat_inc(y_reg) : y_reg;
        frame_good   = !bad_line_reg && !line_bad &&
                       (y_after_line == CNT_W'(V_ACTIVE));
        pix_base     = hfall ? '0 : pix_cnt_reg;
        y_base       = vfall ? '0 : y_after_line;
        sum_base     = vfall ? '0 : sum_reg;
        sum_term     = iVGA_BLANK ? {iVGA_R ^ iVGA_G ^ iVGA_B, iVGA_G} : '0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pix_cnt_reg     <= '0;
            y_reg           <= '0;
            sum_reg         <= '0;
            bad_line_reg    <= 1'b0;
            seen_vs_reg     <= 1'b0;
            coord_x_reg     <= '0;
            coord_y_reg     <= '0;
            line_pixels_reg <= '0;
            frame_lines_reg <= '0;
            r_reg           <= '0;
            g_reg           <= '0;
            b_reg           <= '0;
            pixel_valid_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            checksum_reg    <= '0;
        end else begin
            pixel_valid_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            if (enable) begin
                if (line_has) begin
                    line_pixels_reg <= pix_cnt_reg;
                end
                pix_cnt_reg  <= iVGA_BLANK ? sat_inc(pix_base) : pix_base;
                y_reg        <= y_base;
                sum_reg      <= sum_base + sum_term;
                bad_line_reg <= vfall ? 1'b0 : (bad_line_reg | line_bad);
                if (vfall) begin
                    seen_vs_reg <= 1'b1;
                    // The first vsync after reset only opens a frame.
                    if (seen_vs_reg) begin
                        frame_lines_reg <= y_after_line;
                        checksum_reg    <= sum_reg;
                        frame_done_reg  <= 1'b1;
                    end
                end
                if (iVGA_BLANK) begin
                    pixel_valid_reg <= 1'b1;
                    coord_x_reg     <= pix_base;
                    coord_y_reg     <= y_base;
                    r_reg           <= iVGA_R;
                    g_reg           <= iVGA_G;
                    b_reg           <= iVGA_B;
                end
            end
        end
    end

    // ---------------- lock FSM
    dec_state_t     state_reg, state_next;
    logic [GW-1:0]  good_cnt_reg, good_cnt_next;
    logic           locked_reg, locked_next;
    logic           error_reg, error_next;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= S_SEARCH;
            good_cnt_reg <= '0;
            locked_reg   <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            good_cnt_reg <= good_cnt_next;
            locked_reg   <= locked_next;
            error_reg    <= error_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        good_cnt_next = good_cnt_reg;
        locked_next   = locked_reg;
        error_next    = error_reg;
        if (vfall) begin
            case (state_reg)
                S_SEARCH: begin
                    state_next    = S_MEASURE;
                    good_cnt_next = '0;
                end
                S_MEASURE: begin
                    if (!frame_good) begin
                        good_cnt_next = '0;
                    end else if (good_cnt_reg == GW'(LOCK_FRAMES - 1)) begin
                        state_next    = S_LOCKED;
                        locked_next   = 1'b1;
                        good_cnt_next = '0;
                    end else begin
                        good_cnt_next = good_cnt_reg + 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (!frame_good) begin
                        error_next  = 1'b1;
                        locked_next = 1'b0;
                        state_next  = S_SEARCH;
                    end
                end
                default: state_next = S_SEARCH;
            endcase
        end
    end

    // ---------------- outputs
    assign oCoord_X     = coord_x_reg;
    assign oCoord_Y     = coord_y_reg;
    assign oPixel_valid = pixel_valid_reg;
    assign oR           = r_reg;
    assign oG           = g_reg;
    assign oB           = b_reg;
    assign oFrame_done  = frame_done_reg;
    assign oLocked      = locked_reg;
    assign oLine_pixels = line_pixels_reg;
    assign oFrame_lines = frame_lines_reg;
    assign oChecksum    = checksum_reg;
    assign oError       = error_reg;

endmodule

// File: tb/tb_vga_frame_decoder.sv
// Directed bench for vga_frame_decoder using a reduced 16x8 visible raster
// (line = 16 visible + 2 front porch + 3 sync + 2 back porch pixels;
// frame = 1 back-porch line, 8 visible lines, 1 front-porch line,
// 2 vsync lines). vsync falls at the start of the first sync line, so every
// call to send_frame ends the frame it carries.
module tb_vga_frame_decoder;

    localparam int H    = 16;
    localparam int V    = 8;
    localparam int FP   = 2;
    localparam int SYNC = 3;
    localparam int BPP  = 2;
    localparam int LINE = H + FP + SYNC + BPP;

    logic       clock = 1'b0;
    logic       resetn;
    logic       enable;
    logic       hs, vs, bl;
    logic [7:0] r, g, b;
    logic       en_mask;

    logic [9:0]  oCoord_X, oCoord_Y, oLine_pixels, oFrame_lines;
    logic        oPixel_valid, oFrame_done, oLocked, oError;
    logic [7:0]  oR, oG, oB;
    logic [15:0] oChecksum;

    vga_frame_decoder #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(2)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .enable       (enable),
        .iVGA_H_SYNC  (hs),
        .iVGA_V_SYNC  (vs),
        .iVGA_BLANK   (bl),
        .iVGA_R       (r),
        .iVGA_G       (g),
        .iVGA_B       (b),
        .oCoord_X     (oCoord_X),
        .oCoord_Y     (oCoord_Y),
        .oPixel_valid (oPixel_valid),
        .oR           (oR),
        .oG           (oG),
        .oB           (oB),
        .oFrame_done  (oFrame_done),
        .oLocked      (oLocked),
        .oLine_pixels (oLine_pixels),
        .oFrame_lines (oFrame_lines),
        .oChecksum    (oChecksum),
        .oError       (oError)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // ---------------- output monitor (samples 1 time unit after posedge)
    int          pv_count, x0_count, fd_count;
    logic [9:0]  max_x, max_y, first_x, first_y;
    logic [7:0]  first_r, first_g;
    bit          have_first;
    logic [9:0]  cap_lines;
    logic [15:0] cap_sum;
    logic        cap_lock;

    task automatic clear_stats();
        pv_count = 0; x0_count = 0; fd_count = 0;
        max_x = '0; max_y = '0; have_first = 1'b0;
        first_x = '0; first_y = '0; first_r = '0; first_g = '0;
    endtask

    always @(posedge clock) begin
        #1;
        if (oPixel_valid) begin
            pv_count++;
            if (oCoord_X == 10'd0) x0_count++;
            if (oCoord_X > max_x) max_x = oCoord_X;
            if (oCoord_Y > max_y) max_y = oCoord_Y;
            if (!have_first) begin
                have_first = 1'b1;
                first_x = oCoord_X; first_y = oCoord_Y;
                first_r = oR;       first_g = oG;
            end
        end
        if (oFrame_done) begin
            fd_count++;
            cap_lines = oFrame_lines;
            cap_sum   = oChecksum;
            cap_lock  = oLocked;
        end
    end

    // ---------------- stimulus
    function automatic logic [23:0] pix_rgb(input int mode, input int k);
        if (mode == 0) return 24'hFFFFFF;
        case (k / 2)
            0: return 24'hFF0000;
            1: return 24'hFFFFFF;
            2: return 24'hFFFF00;
            3: return 24'h00FFFF;
            4: return 24'h00FF00;
            5: return 24'hFF00FF;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic send_pixel(input logic h_in, input logic v_in, input logic b_in,
                              input logic [23:0] rgb);
        @(negedge clock);
        hs = h_in; vs = v_in; bl = b_in;
        {r, g, b} = rgb;
        enable = en_mask;
        @(negedge clock);
        enable = 1'b0;
    endtask

    // vs_a holds before the hsync pulse, vs_b from the hsync pulse onward.
    task automatic send_line(input int nvis, input logic vs_a, input logic vs_b, input int mode);
        for (int k = 0; k < LINE; k++) begin
            send_pixel(!(k >= H + FP && k < H + FP + SYNC),
                       (k < H + FP) ? vs_a : vs_b,
                       k < nvis, pix_rgb(mode, k));
        end
    endtask

    task automatic send_frame(input int mode, input int short_line, input bit coincide);
        send_line(0, 1'b1, 1'b1, mode);
        for (int l = 0; l < V; l++) begin
            send_line((l == short_line) ? H - 1 : H, 1'b1,
                      (coincide && l == V - 1) ? 1'b0 : 1'b1, mode);
        end
        if (!coincide) send_line(0, 1'b1, 1'b1, mode);
        send_line(0, 1'b0, 1'b0, mode);
        send_line(0, 1'b0, 1'b0, mode);
    endtask

    initial begin
        hs = 1'b1; vs = 1'b1; bl = 1'b0; r = '0; g = '0; b = '0;
        enable = 1'b0; en_mask = 1'b1; resetn = 1'b1;
        clear_stats();
        #3 resetn = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("rst_locked",   oLocked, 0);
        check_eq("rst_error",    oError, 0);
        check_eq("rst_pvalid",   oPixel_valid, 0);
        check_eq("rst_fdone",    oFrame_done, 0);
        check_eq("rst_linepix",  oLine_pixels, 0);
        check_eq("rst_checksum", oChecksum, 0);
        resetn = 1'b1;

        // Solid white: 128 pixels * 0xFFFF mod 2^16 = 0xFF80.
        clear_stats();
        send_frame(0, -1, 0);
        check_eq("first_vfall_no_done", fd_count, 0);
        check_eq("unlocked_f1", oLocked, 0);
        send_frame(0, -1, 0);
        check_eq("done_f2", fd_count, 1);
        check_eq("lines_f2", cap_lines, V);
        check_eq("sum_white_f2", cap_sum, 16'hFF80);
        check_eq("unlocked_f2", oLocked, 0);
        send_frame(0, -1, 0);
        check_eq("locked_f3", oLocked, 1);
        check_eq("lock_at_done", cap_lock, 1);
        check_eq("line_pixels", oLine_pixels, H);
        check_eq("frame_lines", oFrame_lines, V);
        check_eq("sum_white", oChecksum, 16'hFF80);
        check_eq("no_error", oError, 0);

        // Colour bars (2 px per bar): per-line sum 0x7FFF8, x8 -> 0xFFC0.
        clear_stats();
        send_frame(1, -1, 0);
        check_eq("bars_pv_count", pv_count, H * V);
        check_eq("bars_first_x", first_x, 0);
        check_eq("bars_first_y", first_y, 0);
        check_eq("bars_first_r", first_r, 8'hFF);
        check_eq("bars_first_g", first_g, 8'h00);
        check_eq("bars_max_x", max_x, H - 1);
        check_eq("bars_max_y", max_y, V - 1);
        check_eq("bars_x_wraps", x0_count, V);
        check_eq("bars_done", fd_count, 1);
        check_eq("bars_sum", cap_sum, 16'hFFC0);
        check_eq("bars_locked", oLocked, 1);

        // hsync and vsync falling in the same sample.
        clear_stats();
        send_frame(0, -1, 1);
        check_eq("coin_done", fd_count, 1);
        check_eq("coin_lines", cap_lines, V);
        check_eq("coin_linepix", oLine_pixels, H);
        check_eq("coin_sum", cap_sum, 16'hFF80);
        check_eq("coin_no_error", oError, 0);
        check_eq("coin_locked", oLocked, 1);
        send_frame(0, -1, 0);
        check_eq("post_coin_locked", oLocked, 1);
        check_eq("post_coin_error", oError, 0);

        // Strobe held low for a whole (colour-bar) frame.
        clear_stats();
        en_mask = 1'b0;
        send_frame(1, -1, 0);
        en_mask = 1'b1;
        check_eq("noen_pv_count", pv_count, 0);
        check_eq("noen_done", fd_count, 0);
        check_eq("noen_checksum", oChecksum, 16'hFF80);
        check_eq("noen_linepix", oLine_pixels, H);
        check_eq("noen_locked", oLocked, 1);
        send_frame(0, -1, 0);
        check_eq("resume_locked", oLocked, 1);
        check_eq("resume_sum", cap_sum, 16'hFF80);

        // One short line while locked: 127 white pixels -> 0xFF81.
        send_frame(0, 3, 0);
        check_eq("short_error", oError, 1);
        check_eq("short_unlocked", oLocked, 0);
        check_eq("short_sum", cap_sum, 16'hFF81);
        check_eq("short_lines", cap_lines, V);
        send_frame(0, -1, 0);
        check_eq("search_unlocked", oLocked, 0);
        send_frame(0, -1, 0);
        check_eq("measure_unlocked", oLocked, 0);
        send_frame(0, -1, 0);
        check_eq("relocked", oLocked, 1);
        check_eq("error_sticky", oError, 1);

        // Reset in the middle of a frame.
        send_line(0, 1'b1, 1'b1, 0);
        for (int l = 0; l < 4; l++) send_line(H, 1'b1, 1'b1, 0);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        check_eq("mid_rst_locked", oLocked, 0);
        check_eq("mid_rst_error", oError, 0);
        check_eq("mid_rst_linepix", oLine_pixels, 0);
        check_eq("mid_rst_lines", oFrame_lines, 0);
        check_eq("mid_rst_checksum", oChecksum, 0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        clear_stats();
        for (int l = 4; l < V; l++) send_line(H, 1'b1, 1'b1, 0);
        send_line(0, 1'b1, 1'b1, 0);
        send_line(0, 1'b0, 1'b0, 0);
        send_line(0, 1'b0, 1'b0, 0);
        check_eq("after_rst_no_done", fd_count, 0);
        check_eq("after_rst_unlocked", oLocked, 0);
        send_frame(0, -1, 0);
        check_eq("after_rst_f1_unlocked", oLocked, 0);
        check_eq("after_rst_f1_done", fd_count, 1);
        send_frame(0, -1, 0);
        check_eq("after_rst_f2_locked", oLocked, 1);
        check_eq("after_rst_no_error", oError, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
